// File: rtl/updn_counter_param.sv
// Parametrised load/up/down counter with wrap or saturate at [MIN_VAL, MAX_VAL],
// terminal-count outputs, sticky overflow/underflow flags and a limit-event pulse.
module updn_counter_param #(
  parameter int WIDTH    = 8,
  parameter int STEP_W   = 1,
  parameter int MIN_VAL  = 0,
  parameter int MAX_VAL  = 2**WIDTH-1,
  parameter int RST_VAL  = 0,
  parameter int SATURATE = 0
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              ld_cnt_,
  input  logic              updn_cnt,
  input  logic              count_enb,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              clr_flags,
  output logic [WIDTH-1:0]  data_out,
  output logic              tc_up,
  output logic              tc_dn,
  output logic              ovf,
  output logic              unf,
  output logic              lim_evt
);

  // Two guard bits: one for the carry out of data_out + step, one for sign on the down path.
  localparam int EW = WIDTH + 2;
  localparam logic signed [EW-1:0] MIN_X = EW'(MIN_VAL);
  localparam logic signed [EW-1:0] MAX_X = EW'(MAX_VAL);
  localparam logic signed [EW-1:0] ONE_X = EW'(1);

  if (!(MIN_VAL < MAX_VAL && MAX_VAL <= 2**WIDTH-1 &&
        MIN_VAL <= RST_VAL && RST_VAL <= MAX_VAL &&
        2**STEP_W-1 <= MAX_VAL-MIN_VAL+1)) begin : g_param_err
    $error("updn_counter_param: illegal WIDTH/STEP_W/MIN_VAL/MAX_VAL/RST_VAL combination");
  end

  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    logic signed [EW-1:0] vx;
    vx = $signed(EW'(v));
    if (vx < MIN_X) return WIDTH'(MIN_VAL);
    if (vx > MAX_X) return WIDTH'(MAX_VAL);
    return v;
  endfunction

  // Step never exceeds the range size, so a single wrap always lands inside it.
  function automatic logic [WIDTH-1:0] limit_up(input logic signed [EW-1:0] s);
    if (SATURATE != 0) return WIDTH'(MAX_VAL);
    return WIDTH'(MIN_X + (s - MAX_X - ONE_X));
  endfunction

  function automatic logic [WIDTH-1:0] limit_dn(input logic signed [EW-1:0] d);
    if (SATURATE != 0) return WIDTH'(MIN_VAL);
    return WIDTH'(MAX_X - (MIN_X - d - ONE_X));
  endfunction

  logic signed [EW-1:0] cur_x, step_x, sum_x, dif_x;
  logic [WIDTH-1:0]     cnt_nxt;
  logic                 ovf_set, unf_set;

  always_comb begin
    cur_x   = $signed(EW'(data_out));
    step_x  = $signed(EW'(step));
    sum_x   = cur_x + step_x;
    dif_x   = cur_x - step_x;
    cnt_nxt = data_out;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (!ld_cnt_) begin
      cnt_nxt = clamp_load(data_in);
    end else if (count_enb && step != '0) begin
      if (updn_cnt) begin
        if (sum_x > MAX_X) begin
          cnt_nxt = limit_up(sum_x);
          ovf_set = 1'b1;
        end else begin
          cnt_nxt = WIDTH'(sum_x);
        end
      end else begin
        if (dif_x < MIN_X) begin
          cnt_nxt = limit_dn(dif_x);
          unf_set = 1'b1;
        end else begin
          cnt_nxt = WIDTH'(dif_x);
        end
      end
    end
  end

  // Register stage: a crossing on the same edge as clr_flags wins for its own flag.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      data_out <= WIDTH'(RST_VAL);
      ovf      <= 1'b0;
      unf      <= 1'b0;
      lim_evt  <= 1'b0;
    end else begin
      data_out <= cnt_nxt;
      ovf      <= (ovf & ~clr_flags) | ovf_set;
      unf      <= (unf & ~clr_flags) | unf_set;
      lim_evt  <= ovf_set | unf_set;
    end
  end

  assign tc_up = (data_out == WIDTH'(MAX_VAL));
  assign tc_dn = (data_out == WIDTH'(MIN_VAL));

endmodule

// File: tb/tb_updn_counter_param.sv
// Directed bench: default 8-bit wrap counter plus 10..200 range in saturate and wrap modes.
module tb_updn_counter_param;

  logic       clk = 1'b0;
  logic       rst_, ld_cnt_, updn_cnt, count_enb, clr_flags;
  logic [3:0] step;
  logic [7:0] data_in;

  logic [7:0] d_out, s_out, w_out;
  logic d_tcu, d_tcd, d_ovf, d_unf, d_evt;
  logic s_tcu, s_tcd, s_ovf, s_unf, s_evt;
  logic w_tcu, w_tcd, w_ovf, w_unf, w_evt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  updn_counter_param u_def (
    .clk(clk), .rst_(rst_), .ld_cnt_(ld_cnt_), .updn_cnt(updn_cnt), .count_enb(count_enb),
    .step(step[0:0]), .data_in(data_in), .clr_flags(clr_flags), .data_out(d_out),
    .tc_up(d_tcu), .tc_dn(d_tcd), .ovf(d_ovf), .unf(d_unf), .lim_evt(d_evt)
  );

  updn_counter_param #(.WIDTH(8), .STEP_W(4), .MIN_VAL(10), .MAX_VAL(200), .RST_VAL(10),
                       .SATURATE(1)) u_sat (
    .clk(clk), .rst_(rst_), .ld_cnt_(ld_cnt_), .updn_cnt(updn_cnt), .count_enb(count_enb),
    .step(step), .data_in(data_in), .clr_flags(clr_flags), .data_out(s_out),
    .tc_up(s_tcu), .tc_dn(s_tcd), .ovf(s_ovf), .unf(s_unf), .lim_evt(s_evt)
  );

  updn_counter_param #(.WIDTH(8), .STEP_W(4), .MIN_VAL(10), .MAX_VAL(200), .RST_VAL(10),
                       .SATURATE(0)) u_wrp (
    .clk(clk), .rst_(rst_), .ld_cnt_(ld_cnt_), .updn_cnt(updn_cnt), .count_enb(count_enb),
    .step(step), .data_in(data_in), .clr_flags(clr_flags), .data_out(w_out),
    .tc_up(w_tcu), .tc_dn(w_tcd), .ovf(w_ovf), .unf(w_unf), .lim_evt(w_evt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst_ = 1'b0; ld_cnt_ = 1'b1; updn_cnt = 1'b1; count_enb = 1'b0;
    clr_flags = 1'b0; step = 4'd1; data_in = 8'h00;
    tick(); tick();
    rst_ = 1'b1;
    tick();
    check("rst_data", {24'd0, d_out}, 32'd0);
    check("rst_ovf", {31'd0, d_ovf}, 32'd0);
    check("rst_unf", {31'd0, d_unf}, 32'd0);
    check("rst_evt", {31'd0, d_evt}, 32'd0);
    check("rst_tcdn", {31'd0, d_tcd}, 32'd1);
    check("rst_tcup", {31'd0, d_tcu}, 32'd0);
    check("rst_sat_data", {24'd0, s_out}, 32'd10);

    // 1: mid-count async reset, then FE -> FF -> 00 -> 01
    count_enb = 1'b1;
    tick(); tick(); tick();
    check("t1_count3", {24'd0, d_out}, 32'd3);
    rst_ = 1'b0;
    #2;
    check("t1_async_rst", {24'd0, d_out}, 32'd0);
    rst_ = 1'b1;
    ld_cnt_ = 1'b0; count_enb = 1'b0; data_in = 8'hFE;
    tick();
    check("t1_load_fe", {24'd0, d_out}, 32'hFE);
    ld_cnt_ = 1'b1; count_enb = 1'b1; updn_cnt = 1'b1;
    tick();
    check("t1_ff", {24'd0, d_out}, 32'hFF);
    check("t1_ff_evt", {31'd0, d_evt}, 32'd0);
    check("t1_ff_ovf", {31'd0, d_ovf}, 32'd0);
    check("t1_ff_tcup", {31'd0, d_tcu}, 32'd1);
    tick();
    check("t1_00", {24'd0, d_out}, 32'h00);
    check("t1_00_evt", {31'd0, d_evt}, 32'd1);
    check("t1_00_ovf", {31'd0, d_ovf}, 32'd1);
    tick();
    check("t1_01", {24'd0, d_out}, 32'h01);
    check("t1_01_evt", {31'd0, d_evt}, 32'd0);
    check("t1_01_ovf", {31'd0, d_ovf}, 32'd1);

    // 2: hold, then underflow wrap from 00
    count_enb = 1'b0;
    repeat (5) tick();
    check("t2_hold", {24'd0, d_out}, 32'h01);
    ld_cnt_ = 1'b0; data_in = 8'h00;
    tick();
    ld_cnt_ = 1'b1; count_enb = 1'b1; updn_cnt = 1'b0;
    tick();
    check("t2_dn_ff", {24'd0, d_out}, 32'hFF);
    check("t2_unf", {31'd0, d_unf}, 32'd1);
    check("t2_evt", {31'd0, d_evt}, 32'd1);

    // 3: saturate range 10..200 (flags cleared on the load edge)
    count_enb = 1'b0; ld_cnt_ = 1'b0; data_in = 8'd195; clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    check("t3_load195", {24'd0, s_out}, 32'd195);
    check("t3_ovf_clr", {31'd0, s_ovf}, 32'd0);
    ld_cnt_ = 1'b1; count_enb = 1'b1; updn_cnt = 1'b1; step = 4'd7;
    tick();
    check("t3_sat1", {24'd0, s_out}, 32'd200);
    check("t3_sat1_evt", {31'd0, s_evt}, 32'd1);
    check("t3_sat1_ovf", {31'd0, s_ovf}, 32'd1);
    check("t3_wrap_side", {24'd0, w_out}, 32'd11);
    tick();
    check("t3_sat2", {24'd0, s_out}, 32'd200);
    check("t3_sat2_evt", {31'd0, s_evt}, 32'd1);
    check("t3_sat2_tcup", {31'd0, s_tcu}, 32'd1);
    count_enb = 1'b0; ld_cnt_ = 1'b0; data_in = 8'd5;
    tick();
    check("t3_clamp", {24'd0, s_out}, 32'd10);
    check("t3_clamp_tcdn", {31'd0, s_tcd}, 32'd1);
    check("t3_clamp_evt", {31'd0, s_evt}, 32'd0);
    check("t3_clamp_unf", {31'd0, s_unf}, 32'd0);
    check("t3_ovf_kept", {31'd0, s_ovf}, 32'd1);

    // 4: wrap range, underflow 12-5 -> 198, then step=0 hold
    data_in = 8'd12;
    tick();
    ld_cnt_ = 1'b1; count_enb = 1'b1; updn_cnt = 1'b0; step = 4'd5;
    tick();
    check("t4_wrap198", {24'd0, w_out}, 32'd198);
    check("t4_unf", {31'd0, w_unf}, 32'd1);
    check("t4_evt", {31'd0, w_evt}, 32'd1);
    step = 4'd0;
    tick();
    check("t4_step0_hold", {24'd0, w_out}, 32'd198);
    check("t4_step0_evt", {31'd0, w_evt}, 32'd0);

    // 5: overflow on the same edge as clr_flags
    step = 4'd5; updn_cnt = 1'b1; clr_flags = 1'b1;
    tick();
    check("t5_wrap12", {24'd0, w_out}, 32'd12);
    check("t5_ovf_set", {31'd0, w_ovf}, 32'd1);
    check("t5_unf_clr", {31'd0, w_unf}, 32'd0);
    count_enb = 1'b0;
    tick();
    clr_flags = 1'b0;
    check("t5_ovf_clr", {31'd0, w_ovf}, 32'd0);

    // Exactly reaching MAX is not a crossing
    ld_cnt_ = 1'b0; data_in = 8'd195;
    tick();
    ld_cnt_ = 1'b1; count_enb = 1'b1; updn_cnt = 1'b1; step = 4'd5;
    tick();
    check("t5_exact_max", {24'd0, w_out}, 32'd200);
    check("t5_exact_evt", {31'd0, w_evt}, 32'd0);
    check("t5_exact_ovf", {31'd0, w_ovf}, 32'd0);

    // 6: load beats count
    ld_cnt_ = 1'b0; count_enb = 1'b1; updn_cnt = 1'b1; step = 4'd1; data_in = 8'h40;
    tick();
    check("t6_load_wins", {24'd0, d_out}, 32'h40);
    check("t6_evt", {31'd0, d_evt}, 32'd0);
    ld_cnt_ = 1'b1; count_enb = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/updn_counter_param.md
Name: updn_counter_param

Overview:
- Parametrised successor to the team's 8-bit load/up/down counter. Generalised in width, count range and step size.
- Adds a selectable wrap or saturate mode, terminal-count outputs, and sticky overflow/underflow flags.
- Used as a configurable event/position counter wherever the fixed 8-bit counter was.
- Has a matching property checker; all control timing is kept compatible with the 8-bit version.

Parameters:
- WIDTH, 8: counter width in bits.
- STEP_W, 1: width of the step input.
- MIN_VAL, 0: lowest legal count value.
- MAX_VAL, 2**WIDTH-1: highest legal count value.
- RST_VAL, 0: value of data_out after reset.
- SATURATE, 0: 0 = wrap at range limits; 1 = clamp at range limits.
- Elaboration-time error unless all of the following hold:
  - MIN_VAL < MAX_VAL <= 2**WIDTH-1
  - MIN_VAL <= RST_VAL <= MAX_VAL
  - 2**STEP_W-1 <= MAX_VAL-MIN_VAL+1

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_  in  1  asynchronous active-low reset.
- ld_cnt_  in  1  synchronous load, active-low.
- updn_cnt  in  1  1 = count up, 0 = count down.
- count_enb  in  1  count enable, active-high.
- step  in  STEP_W  amount added or subtracted per enabled cycle.
- data_in  in  WIDTH  load value.
- clr_flags  in  1  synchronous clear of ovf and unf.
- data_out  out  WIDTH  registered count.
- tc_up  out  1  combinational, data_out == MAX_VAL.
- tc_dn  out  1  combinational, data_out == MIN_VAL.
- ovf  out  1  sticky overflow flag.
- unf  out  1  sticky underflow flag.
- lim_evt  out  1  registered one-cycle pulse: a limit crossing took effect this cycle.

Behaviour:
- Reset: rst_=0 asynchronously forces data_out=RST_VAL and ovf=unf=lim_evt=0. Held regardless of clk. Reset mid-count discards the operation in flight.
- Latency: controls sampled at edge N; the result is visible on data_out after edge N (one cycle). This matches the |=> timing of the 8-bit counter's checks.
- Priority per edge: load > count > hold.
- Load (ld_cnt_=0):
  - data_out <= data_in, clamped into [MIN_VAL, MAX_VAL].
  - Clamping sets no flags; lim_evt=0.
  - count_enb, updn_cnt and step are ignored.
- Hold (ld_cnt_=1, count_enb=0, or step=0): data_out unchanged, lim_evt=0.
- Count up (ld_cnt_=1, count_enb=1, updn_cnt=1):
  - Compute s = data_out + step in WIDTH+1 bits; there is no truncation before the compare.
  - s <= MAX_VAL: data_out <= s.
  - s > MAX_VAL, SATURATE=1: data_out <= MAX_VAL.
  - s > MAX_VAL, SATURATE=0: data_out <= MIN_VAL + (s - MAX_VAL - 1).
  - In both over-range cases, ovf is set and lim_evt=1 for that cycle.
- Count down: mirror of count up.
  - Compute d = data_out - step, signed, WIDTH+1 bits.
  - d >= MIN_VAL: data_out <= d.
  - d < MIN_VAL, SATURATE=1: data_out <= MIN_VAL.
  - d < MIN_VAL, SATURATE=0: data_out <= MAX_VAL - (MIN_VAL - d - 1).
  - In both under-range cases, unf is set and lim_evt=1.
- Saturate mode at the limit: counting further into the limit (e.g. data_out=MAX_VAL, count up) keeps the value and sets ovf/lim_evt again on every such cycle.
- Exactly-at-limit results (s == MAX_VAL or d == MIN_VAL) are not a crossing: no flag, no lim_evt.
- Flags:
  - clr_flags=1 clears ovf and unf on the next edge.
  - If a clear and a new crossing fall on the same edge, set wins for the crossing flag; the other flag still clears.
  - Flags are unaffected by load.
- tc_up and tc_dn follow data_out combinationally. Both are never 1 together, since MIN_VAL < MAX_VAL.
- Default parameters (8-bit, step=1, wrap) give behaviour cycle-identical to the 8-bit counter: reset to 0, hold, +1/-1 with modulo-256 wrap.

Test Plan:
1. Defaults, counting (mid-count): rst_=0 pulse mid-count -> data_out=0 immediately, without waiting for clk. Then ld_cnt_=0, data_in=8'hFE, then count up x3 -> data_out FE, FF, 00, 01. ovf=1 from the wrap edge. lim_evt high only on the FF->00 cycle.
2. Defaults, count_enb=0 for 5 cycles with ld_cnt_=1 -> data_out holds its value. Then load 8'h00 and count down x1 -> data_out=FF, unf=1.
3. MIN_VAL=10, MAX_VAL=200, STEP_W=4, SATURATE=1:
   - load 195, step=7, count up -> 200, then 200 again; tc_up=1, ovf=1, lim_evt on both edges.
   - load 5 -> data_out=10 (clamped), tc_dn=1, no flag.
4. Same range, SATURATE=0: load 12, step=5, count down -> 198 (10 - 3 wraps to 200 - 2), unf=1. Next step=0 with count_enb=1 -> holds 198, lim_evt=0.
5. Flag race: overflow crossing on the same edge as clr_flags=1, with unf previously set -> ovf=1, unf=0. Next edge: clr_flags=1, no crossing -> ovf=0.
6. Priority: ld_cnt_=0 with count_enb=1, updn_cnt=1 and data_in=8'h40 -> data_out=8'h40 (load wins), no lim_evt.
